// File: rtl/flex_clock_driver_pkg.sv
// Shared definitions for the flexible-clock driver: FSM state encodings
// and small helpers used by the top level.
package flex_clock_driver_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  // Generator states: IDLE (no clock), HIGH phase, LOW phase
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // True whenever the generator is producing a clock
  function automatic logic state_is_running(input state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/flex_clock_driver_phase_counter.sv
// Phase-length counter: loaded with a phase length at the start of a phase,
// counts down once per cycle and flags the final cycle of the phase.
module flex_clock_driver_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Load len-1 at phase start (len is never 0), then count down to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= len - CNT_W'(1);
    end else if (count_reg != '0) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign last = (count_reg == '0);

endmodule

// File: rtl/flex_clock_driver.sv
// Programmable clock-value / gate source for a flexible-clock generator.
// Produces a toggling clock value with one-cycle update strobes, and applies
// gate updates only while the generated clock is low.
module flex_clock_driver
  import flex_clock_driver_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter logic INIT_GATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cfg_hi,
  input  logic [CNT_W-1:0] cfg_lo,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             gate_req,
  input  logic             gate_req_en,
  output logic             clk_val_out,
  output logic             clk_val_en,
  output logic             cond_out,
  output logic             cond_en,
  output logic             running,
  output logic [CNT_W-1:0] edge_cnt
);

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] hi_act_reg;
  logic [CNT_W-1:0] lo_act_reg;
  logic [CNT_W-1:0] shadow_hi_reg;
  logic [CNT_W-1:0] shadow_lo_reg;
  logic             shadow_valid_reg;
  logic             stop_pending_reg;
  logic             gate_pending_reg;
  logic             gate_value_reg;
  logic             rise;
  logic             fall;
  logic             copy_cfg;
  logic [CNT_W-1:0] hi_eff;
  logic             phase_load;
  logic [CNT_W-1:0] phase_len;
  logic             phase_last;

  // A zero phase length behaves as a one-cycle phase
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  flex_clock_driver_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .load (phase_load),
    .len  (phase_len),
    .last (phase_last)
  );

  // Next-state decode; a pending or fresh stop ends generation from LOW
  always_comb begin
    state_next = state_reg;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start && !stop) begin
          state_next = ST_HIGH;
          rise       = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_next = ST_LOW;
          fall       = 1'b1;
        end
      end
      ST_LOW: begin
        if (stop || stop_pending_reg) begin
          state_next = ST_IDLE;
        end else if (phase_last) begin
          state_next = ST_HIGH;
          rise       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shadow config is promoted while idle or on a period boundary, so the
  // new high length already applies to the phase that starts at this rise
  always_comb begin
    copy_cfg   = shadow_valid_reg && ((state_reg == ST_IDLE) || rise);
    hi_eff     = copy_cfg ? clamp_len(shadow_hi_reg) : hi_act_reg;
    phase_load = rise | fall;
    phase_len  = rise ? hi_eff : lo_act_reg;
  end

  // FSM state and registered clock outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      clk_val_out <= 1'b0;
      clk_val_en  <= 1'b0;
      edge_cnt    <= '0;
    end else begin
      state_reg  <= state_next;
      clk_val_en <= rise | fall;
      if (rise) begin
        clk_val_out <= 1'b1;
        edge_cnt    <= edge_cnt + CNT_W'(1);
      end else if (fall) begin
        clk_val_out <= 1'b0;
      end
    end
  end

  // Shadow/active configuration handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_act_reg       <= CNT_W'(1);
      lo_act_reg       <= CNT_W'(1);
      shadow_hi_reg    <= '0;
      shadow_lo_reg    <= '0;
      shadow_valid_reg <= 1'b0;
    end else if (copy_cfg) begin
      hi_act_reg       <= clamp_len(shadow_hi_reg);
      lo_act_reg       <= clamp_len(shadow_lo_reg);
      shadow_valid_reg <= 1'b0;
    end else if (cfg_valid && !shadow_valid_reg) begin
      shadow_hi_reg    <= cfg_hi;
      shadow_lo_reg    <= cfg_lo;
      shadow_valid_reg <= 1'b1;
    end
  end

  // Remember a stop seen during HIGH until the falling toggle has been issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_pending_reg <= 1'b0;
    end else if (state_next == ST_IDLE) begin
      stop_pending_reg <= 1'b0;
    end else if (stop && state_reg != ST_IDLE) begin
      stop_pending_reg <= 1'b1;
    end
  end

  // Gate updates only land while the generated clock is low; a request in
  // the same cycle as an apply stays pending for the next eligible cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_out         <= INIT_GATE;
      cond_en          <= 1'b0;
      gate_pending_reg <= 1'b0;
      gate_value_reg   <= 1'b0;
    end else begin
      cond_en <= 1'b0;
      if (gate_pending_reg && !clk_val_out) begin
        cond_out         <= gate_value_reg;
        cond_en          <= 1'b1;
        gate_pending_reg <= 1'b0;
      end
      if (gate_req_en) begin
        gate_pending_reg <= 1'b1;
        gate_value_reg   <= gate_req;
      end
    end
  end

  assign cfg_ready = !shadow_valid_reg;
  assign running   = state_is_running(state_reg);

endmodule

// File: tb/tb_flex_clock_driver.sv
// Self-checking bench for flex_clock_driver: directed scenarios with literal
// expectations plus randomized traffic against a phase-age reference model.
module tb_flex_clock_driver;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] cfg_hi = '0;
  logic [CNT_W-1:0] cfg_lo = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             gate_req = 1'b0;
  logic             gate_req_en = 1'b0;
  logic             clk_val_out;
  logic             clk_val_en;
  logic             cond_out;
  logic             cond_en;
  logic             running;
  logic [CNT_W-1:0] edge_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: generator described by "running", current level and
  // the age of the current phase, compared against the active lengths
  bit m_run, m_level, m_stop, m_en, m_cond, m_cond_en;
  bit sh_valid, g_pend, g_val;
  int m_age, m_hi, m_lo, sh_hi, sh_lo, m_edges;

  flex_clock_driver #(
    .CNT_W     (CNT_W),
    .INIT_GATE (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_hi      (cfg_hi),
    .cfg_lo      (cfg_lo),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .start       (start),
    .stop        (stop),
    .gate_req    (gate_req),
    .gate_req_en (gate_req_en),
    .clk_val_out (clk_val_out),
    .clk_val_en  (clk_val_en),
    .cond_out    (cond_out),
    .cond_en     (cond_en),
    .running     (running),
    .edge_cnt    (edge_cnt)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_run = 0; m_level = 0; m_stop = 0; m_en = 0; m_cond = 1; m_cond_en = 0;
    sh_valid = 0; g_pend = 0; g_val = 0;
    m_age = 0; m_hi = 1; m_lo = 1; sh_hi = 0; sh_lo = 0; m_edges = 0;
  endfunction

  // Advance the model by one clock using the inputs presented at that edge
  function automatic void model_step();
    bit rise = 0, fall = 0, go_idle = 0, copy;
    if (!m_run) begin
      if (start && !stop) rise = 1;
    end else if (m_level) begin
      if (m_age + 1 >= m_hi) fall = 1;
    end else begin
      if (m_stop || stop) go_idle = 1;
      else if (m_age + 1 >= m_lo) rise = 1;
    end
    if (go_idle) m_stop = 0;
    else if (m_run && stop) m_stop = 1;
    m_cond_en = 0;
    if (g_pend && !m_level) begin
      m_cond = g_val; m_cond_en = 1; g_pend = 0;
    end
    if (gate_req_en) begin
      g_pend = 1; g_val = gate_req;
    end
    copy = sh_valid && (!m_run || rise);
    if (copy) begin
      m_hi = (sh_hi == 0) ? 1 : sh_hi;
      m_lo = (sh_lo == 0) ? 1 : sh_lo;
      sh_valid = 0;
    end else if (cfg_valid && !sh_valid) begin
      sh_valid = 1; sh_hi = int'(cfg_hi); sh_lo = int'(cfg_lo);
    end
    m_en = rise || fall;
    if (rise) begin
      m_run = 1; m_level = 1; m_age = 0; m_edges = (m_edges + 1) % (1 << CNT_W);
    end else if (fall) begin
      m_level = 0; m_age = 0;
    end else if (go_idle) begin
      m_run = 0; m_age = 0;
    end else begin
      m_age++;
    end
  endfunction

  function automatic void compare_model();
    check("clk_val_out", int'(clk_val_out), int'(m_level));
    check("clk_val_en",  int'(clk_val_en),  int'(m_en));
    check("cond_out",    int'(cond_out),    int'(m_cond));
    check("cond_en",     int'(cond_en),     int'(m_cond_en));
    check("running",     int'(running),     int'(m_run));
    check("cfg_ready",   int'(cfg_ready),   int'(!sh_valid));
    check("edge_cnt",    int'(edge_cnt),    m_edges);
  endfunction

  // One clock: inputs already driven, model advanced, outputs checked 1 after the edge
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    start = 0; stop = 0; cfg_valid = 0; gate_req_en = 0;
  endtask

  // Asynchronous reset pulse, asserted away from the clock edge
  task automatic do_reset();
    start = 0; stop = 0; cfg_valid = 0; gate_req_en = 0;
    rst = 1;
    #1;
    check("rst_clk_val_out", int'(clk_val_out), 0);
    check("rst_clk_val_en",  int'(clk_val_en), 0);
    check("rst_cond_out",    int'(cond_out), 1);
    check("rst_cond_en",     int'(cond_en), 0);
    check("rst_running",     int'(running), 0);
    check("rst_cfg_ready",   int'(cfg_ready), 1);
    check("rst_edge_cnt",    int'(edge_cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // Reset, load a config while idle, then START; returns at cycle t1
  task automatic start_run(input int hi, input int lo);
    do_reset();
    cfg_hi = CNT_W'(hi); cfg_lo = CNT_W'(lo); cfg_valid = 1;
    step();
    step();
    start = 1;
    step();
  endtask

  int exp_clk[6] = '{1, 1, 0, 0, 0, 1};
  int exp_en[6]  = '{1, 0, 1, 0, 0, 1};
  int exp_fast[4] = '{1, 0, 1, 0};

  initial begin
    model_reset();
    #2;

    // Basic waveform, HI=2 LO=3
    start_run(2, 3);
    check("t1_clk", int'(clk_val_out), exp_clk[0]);
    check("t1_en", int'(clk_val_en), exp_en[0]);
    check("t1_edge", int'(edge_cnt), 1);
    for (int k = 1; k < 6; k++) begin
      step();
      check("wave_clk", int'(clk_val_out), exp_clk[k]);
      check("wave_en", int'(clk_val_en), exp_en[k]);
    end
    check("t6_edge", int'(edge_cnt), 2);
    $display("scenario basic_wave: edge_cnt=%0d", edge_cnt);

    // Config change mid-LOW: offered at t4, applied at the t6 rise
    start_run(2, 3);
    for (int k = 0; k < 3; k++) step();
    check("t4_ready", int'(cfg_ready), 1);
    cfg_hi = CNT_W'(1); cfg_lo = CNT_W'(1); cfg_valid = 1;
    step();
    check("t5_ready", int'(cfg_ready), 0);
    check("t5_clk", int'(clk_val_out), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("newcfg_clk", int'(clk_val_out), exp_fast[k]);
      if (k == 0) check("t6_ready", int'(cfg_ready), 1);
    end
    $display("scenario cfg_midlow: done");

    // Gate request during HIGH waits for the falling toggle
    start_run(2, 3);
    gate_req = 0; gate_req_en = 1;
    step();
    check("g_t2_cond_en", int'(cond_en), 0);
    check("g_t2_cond", int'(cond_out), 1);
    step();
    check("g_t3_clk", int'(clk_val_out), 0);
    check("g_t3_cond_en", int'(cond_en), 0);
    step();
    check("g_t4_cond_en", int'(cond_en), 1);
    check("g_t4_cond", int'(cond_out), 0);
    step();
    check("g_t5_cond_en", int'(cond_en), 0);
    $display("scenario gate_hold: cond_out=%0d", cond_out);

    // STOP in first HIGH cycle with HI=4
    start_run(4, 3);
    stop = 1;
    for (int k = 2; k <= 4; k++) begin
      step();
      check("stop_high_clk", int'(clk_val_out), 1);
    end
    step();
    check("stop_t5_clk", int'(clk_val_out), 0);
    check("stop_t5_en", int'(clk_val_en), 1);
    check("stop_t5_run", int'(running), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("stop_idle_run", int'(running), 0);
      check("stop_idle_en", int'(clk_val_en), 0);
    end
    $display("scenario stop_high: running=%0d", running);

    // START+STOP together in IDLE, then zero-length config
    do_reset();
    start = 1; stop = 1;
    step();
    check("ss_run", int'(running), 0);
    check("ss_en", int'(clk_val_en), 0);
    cfg_hi = '0; cfg_lo = '0; cfg_valid = 1;
    step();
    step();
    start = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("zero_cfg_clk", int'(clk_val_out), exp_fast[k]);
      check("zero_cfg_en", int'(clk_val_en), 1);
    end
    $display("scenario start_stop_zero_cfg: done");

    // Async reset mid-HIGH with EDGE_CNT=5
    start_run(1, 1);
    for (int k = 0; k < 8; k++) step();
    check("pre_rst_edge", int'(edge_cnt), 5);
    check("pre_rst_clk", int'(clk_val_out), 1);
    do_reset();
    $display("scenario reset_mid_high: edge_cnt=%0d", edge_cnt);

    // Edge counter wrap: 16 rises with CNT_W=4
    start_run(1, 1);
    for (int k = 0; k < 28; k++) step();
    check("wrap_t29_edge", int'(edge_cnt), 15);
    step();
    step();
    check("wrap_t31_edge", int'(edge_cnt), 0);
    $display("scenario edge_wrap: edge_cnt=%0d", edge_cnt);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cfg_hi      = CNT_W'($urandom_range(0, 5));
      cfg_lo      = CNT_W'($urandom_range(0, 5));
      cfg_valid   = ($urandom_range(0, 7) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      gate_req    = 1'($urandom_range(0, 1));
      gate_req_en = ($urandom_range(0, 5) == 0);
      step();
    end
    $display("scenario random: cycles=4000 edge_cnt=%0d", edge_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
